// File: rtl/axis_sink_monitor_if.sv
// AXI-Stream byte channel between an upstream master and the sink monitor.
// Carries only the handshake and payload; clock and reset stay scalar ports.
interface axis_sink_monitor_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/axis_sink_monitor.sv
// AXI-Stream sink with xorshift32 backpressure, beat/sum counters
// and a sticky protocol-violation monitor.
module axis_sink_monitor #(
  parameter logic [31:0] SEED  = 32'd271828183,
  parameter int          CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_sink_monitor_if.slave   axis,
  input  logic                 stall_en,
  output logic [CNT_W-1:0]     count,
  output logic [7:0]           sum,
  output logic [7:0]           last_data,
  output logic                 err,
  output logic [1:0]           err_code
);

  // An all-zero xorshift state would lock up, so map it to 1.
  localparam logic [31:0] SEED0 = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic logic [31:0] xs_next(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  logic [31:0] rng;
  logic [31:0] rng_nx;
  logic        ready_q;
  logic        beat;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  hold_data;
  logic [7:0]  hold_nx;
  logic [1:0]  code_nx;
  logic        same;

  assign rng_nx      = xs_next(rng);
  assign axis.tready = ready_q;
  assign beat        = axis.tvalid & ready_q;
  assign same        = (axis.tdata == hold_data);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rng       <= SEED0;
      ready_q   <= 1'b0;
      count     <= '0;
      sum       <= '0;
      last_data <= '0;
    end else begin
      rng     <= rng_nx;
      ready_q <= stall_en ? (rng_nx[1:0] != 2'd0) : 1'b1;
      if (beat) begin
        count     <= count + CNT_W'(1);
        sum       <= sum + axis.tdata;
        last_data <= axis.tdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      hold_data <= '0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_nx;
      hold_data <= hold_nx;
      err_code  <= code_nx;
    end
  end

  // Dropped valid outranks changed data when both happen together.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_data;
    code_nx  = err_code;
    unique case (state)
      IDLE: begin
        if (axis.tvalid && !ready_q) begin
          state_nx = WAIT;
          hold_nx  = axis.tdata;
        end
      end
      WAIT: begin
        unique case (1'b1)
          !axis.tvalid: begin
            state_nx = ERR;
            code_nx  = 2'd1;
          end
          axis.tvalid && !same: begin
            state_nx = ERR;
            code_nx  = 2'd2;
          end
          axis.tvalid && same && ready_q: begin
            state_nx = IDLE;
          end
          default: begin
            state_nx = WAIT;
          end
        endcase
      end
      ERR: begin
        state_nx = ERR;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    err = (state == ERR);
  end

endmodule
